// File: rtl/timer_source_mux.sv
// timer_source_mux
// Selects one of NUM_CH {minute, second} timer sources and presents a
// registered, clamped, tear-free pair to the display/compare logic.
// Channel changes and field samples happen only on the 1 Hz tick strobe, so
// both output fields always come from the same sample of the same channel.
// A select request is latched until the next tick (last request wins).
// Requests for channels that do not exist are rejected with a one-cycle
// sel_err pulse. An auto-scan mode rotates through the channels every
// SCAN_TICKS ticks.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   min_in     - flattened minute fields, channel k at [k*FIELD_W +: FIELD_W]
//   sec_in     - flattened second fields, same packing as min_in
//   ch_sel     - requested channel index
//   sel_valid  - one-cycle request to switch to ch_sel
//   auto_en    - level: 1 = SCAN mode, 0 = MANUAL mode
//   tick       - one-cycle update strobe
//   min_out    - registered, clamped minute field
//   sec_out    - registered, clamped second field
//   cur_ch     - channel currently driving the outputs
//   ch_changed - one-cycle pulse when cur_ch changes
//   sel_err    - one-cycle pulse after a request with ch_sel >= NUM_CH
module timer_source_mux #(
   parameter int NUM_CH     = 4,
   parameter int SEL_W      = 2,
   parameter int FIELD_W    = 6,
   parameter int MAX_VAL    = 59,
   parameter int SCAN_TICKS = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH*FIELD_W-1:0]  min_in,
   input  logic [NUM_CH*FIELD_W-1:0]  sec_in,
   input  logic [SEL_W-1:0]           ch_sel,
   input  logic                       sel_valid,
   input  logic                       auto_en,
   input  logic                       tick,
   output logic [FIELD_W-1:0]         min_out,
   output logic [FIELD_W-1:0]         sec_out,
   output logic [SEL_W-1:0]           cur_ch,
   output logic                       ch_changed,
   output logic                       sel_err
);

   localparam int CNT_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;

   // Channel count carried one bit wider so NUM_CH == 2^SEL_W is representable
   localparam logic [SEL_W:0]     NUM_CH_V = (SEL_W+1)'(NUM_CH);
   localparam logic [SEL_W-1:0]   LAST_CH  = SEL_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SCAN_TICKS - 1);
   localparam logic [FIELD_W-1:0] MAX_F    = FIELD_W'(MAX_VAL);

   typedef enum logic {
      MANUAL = 1'b0,
      SCAN   = 1'b1
   } state_t;

   state_t               state;
   logic                 pend;
   logic [SEL_W-1:0]     pend_ch;
   logic [CNT_W-1:0]     scan_cnt;

   logic                 req_ok;
   logic                 req_bad;
   logic                 scan_wrap;
   logic                 apply_req;
   logic [SEL_W-1:0]     nxt_ch;
   logic [FIELD_W-1:0]   raw_min;
   logic [FIELD_W-1:0]   raw_sec;

   function automatic logic [FIELD_W-1:0] clamp(input logic [FIELD_W-1:0] f);
      return (f > MAX_F) ? MAX_F : f;
   endfunction

   // Channel decision for this cycle. Only a tick can move the channel:
   // a same-cycle request beats a latched one, which beats scan advance.
   always_comb begin
      req_ok    = sel_valid && ({1'b0, ch_sel} < NUM_CH_V);
      req_bad   = sel_valid && !req_ok;
      scan_wrap = (state == SCAN) && (scan_cnt == LAST_CNT);
      apply_req = 1'b0;
      nxt_ch    = cur_ch;
      if (tick) begin
         if (req_ok) begin
            nxt_ch    = ch_sel;
            apply_req = 1'b1;
         end else if (pend) begin
            nxt_ch    = pend_ch;
            apply_req = 1'b1;
         end else if (scan_wrap) begin
            nxt_ch = (cur_ch == LAST_CH) ? '0 : cur_ch + SEL_W'(1);
         end
      end
   end

   // Fields of the channel chosen above, so the sample taken at the tick
   // edge already belongs to the new channel.
   always_comb begin
      raw_min = '0;
      raw_sec = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (nxt_ch == SEL_W'(k)) begin
            raw_min = min_in[k*FIELD_W +: FIELD_W];
            raw_sec = sec_in[k*FIELD_W +: FIELD_W];
         end
      end
   end

   // All state, request latch, scan counter and registered outputs. Mode
   // changes follow auto_en on every edge; the channel moves only on ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= MANUAL;
         pend       <= 1'b0;
         pend_ch    <= '0;
         scan_cnt   <= '0;
         cur_ch     <= '0;
         min_out    <= '0;
         sec_out    <= '0;
         ch_changed <= 1'b0;
         sel_err    <= 1'b0;
      end else begin
         sel_err    <= req_bad;
         ch_changed <= tick && (nxt_ch != cur_ch);

         if (tick) begin
            cur_ch  <= nxt_ch;
            min_out <= clamp(raw_min);
            sec_out <= clamp(raw_sec);
         end

         // A request that lands on a tick is consumed directly, which also
         // discards any older pending one.
         if (tick) begin
            if (apply_req) begin
               pend <= 1'b0;
            end
         end else if (req_ok) begin
            pend    <= 1'b1;
            pend_ch <= ch_sel;
         end

         case (state)
            MANUAL: begin
               if (auto_en) begin
                  state    <= SCAN;
                  scan_cnt <= '0;
               end
            end
            SCAN: begin
               if (!auto_en) begin
                  state <= MANUAL;
               end else if (tick) begin
                  // An applied request restarts the dwell for its channel
                  if (apply_req || scan_wrap) begin
                     scan_cnt <= '0;
                  end else begin
                     scan_cnt <= scan_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= MANUAL;
         endcase
      end
   end

endmodule

// File: doc/timer_source_mux.md
Name: timer_source_mux

Overview:
- N-channel successor to the two-way minute/second source selector in the egg-timer datapath.
- Selects one of NUM_CH {minute, second} pairs and drives a registered, tear-free pair to the display/compare logic.
- Channel switches and field samples happen only on the 1 Hz update strobe, so minute and second always come from the same sample.
- Adds a latched select request, an auto-scan mode that rotates through the channels, out-of-range select rejection, and clamping of the output fields.

Parameters:
- NUM_CH, 4: number of timer sources; legal range 2..2^SEL_W.
- SEL_W, 2: width of the channel index.
- FIELD_W, 6: width of each minute and second field.
- MAX_VAL, 59: clamp ceiling for output fields.
- SCAN_TICKS, 3: number of tick strobes each channel is held in auto-scan; must be at least 1.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- min_in, input, NUM_CH*FIELD_W: flattened minute fields; channel k occupies bits [k*FIELD_W +: FIELD_W].
- sec_in, input, NUM_CH*FIELD_W: flattened second fields, same packing as min_in.
- ch_sel, input, SEL_W: requested channel index.
- sel_valid, input, 1: one-cycle request to switch to ch_sel.
- auto_en, input, 1: level input; 1 selects SCAN mode, 0 selects MANUAL.
- tick, input, 1: one-cycle update strobe (1 Hz enable).
- min_out, output, FIELD_W: registered, clamped minute field.
- sec_out, output, FIELD_W: registered, clamped second field.
- cur_ch, output, SEL_W: index of the channel currently driving the outputs.
- ch_changed, output, 1: one-cycle pulse when cur_ch changes.
- sel_err, output, 1: one-cycle pulse when a request carries ch_sel >= NUM_CH.

Behaviour:
- Reset (rst_n=0, asynchronous) clears min_out, sec_out, cur_ch, ch_changed, sel_err, the pending request, pend_ch and scan_cnt to 0, and forces state MANUAL. All outputs stay 0 until the first tick after reset release.
- State machine, two states:
  - MANUAL -> SCAN when auto_en=1 is sampled; scan_cnt is cleared on entry.
  - SCAN -> MANUAL when auto_en=0 is sampled; cur_ch is held.
  - Mode changes take effect on any clock edge; a tick is not required.
- Request latch:
  - sel_valid=1 with ch_sel<NUM_CH loads pend_ch=ch_sel and sets pend=1.
  - A newer request overwrites an older one that has not yet been applied; the last request wins.
  - sel_valid=1 with ch_sel>=NUM_CH leaves pend and pend_ch unchanged and pulses sel_err on the next cycle.
- Application happens only on a cycle with tick=1. Channel priority on that cycle:
  1. A valid sel_valid in the same cycle is applied directly.
  2. Otherwise, if pend=1, pend_ch is applied and pend is cleared.
  3. Otherwise, in SCAN with scan_cnt==SCAN_TICKS-1, cur_ch advances to (cur_ch+1) mod NUM_CH, wrapping from NUM_CH-1 to 0.
  4. Otherwise cur_ch holds.
- Scan counter:
  - In SCAN, scan_cnt increments on each tick and clears when it reaches SCAN_TICKS-1.
  - An applied request also clears scan_cnt, so the requested channel gets a full SCAN_TICKS dwell.
- Output sampling:
  - On a tick cycle, min_out and sec_out load the fields of the new cur_ch (the value after the priority decision) from the same edge.
  - Latency: the outputs are valid at the edge that ends the tick cycle.
  - Between ticks the outputs hold, whatever the inputs do.
- Clamp: each field is output as min(field, MAX_VAL), using an unsigned compare at FIELD_W bits.
- ch_changed pulses for one cycle, registered with cur_ch, only when the new cur_ch differs from the old. Re-selecting the current channel produces no pulse.
- sel_err is registered and one cycle wide. A rejected request on a tick cycle does not block scan advance or application of an earlier pending request.
- Reset asserted mid-operation discards any pending request immediately.

Test Plan:
- Reset: hold rst_n=0 with all inputs nonzero -> min_out=0, sec_out=0, cur_ch=0, both pulses 0. Release reset and apply the first tick with ch0 = (5, 30) -> min_out=5, sec_out=30.
- Deferred select: with ch2 = (12, 7), pulse sel_valid with ch_sel=2 three cycles before a tick -> outputs unchanged until the tick. At the tick edge: min_out=12, sec_out=7, cur_ch=2, ch_changed pulses once.
- Error and last-wins: NUM_CH=3, SEL_W=2. Request ch_sel=3 -> sel_err pulses, pend unchanged. Then request 1, then 0, then tick -> cur_ch=0.
- Auto-scan: SCAN_TICKS=3, auto_en=1, 10 ticks from cur_ch=0 -> cur_ch sequence 0,0,1,1,1,2,2,2,3,3, with wrap 3->0 on the 12th tick.
  - Scan advances on the 3rd, 6th and 9th ticks; cur_ch reads 3 after ticks 9-10, wraps to 0 on tick 12.
- Clamp and coherence: ch1 = (63, 60) -> 59, 59. Change sec_in between ticks -> sec_out holds. A same-cycle tick with sel_valid and ch_sel=1 applies ch1 at that edge.
- Async reset during pending request in SCAN: drop rst_n between two ticks -> outputs 0 within the same cycle. After release, the next tick selects ch0 and MANUAL (auto_en=0) holds ch0.
